sram_sp_be_ctrl: RTL

SRAM_SP_BE_CTRL -- requirements
Module: sram_sp_be_ctrl

---
 rtl/sram_ctrl_pkg.sv | 11 +
 rtl/sram_sp_be_ctrl_if.sv | 31 +++
 rtl/sram_sp_be_array.sv | 42 ++++
 rtl/sram_sp_be_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the byte-enabled single-port SRAM controller.
package sram_ctrl_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/sram_sp_be_ctrl_if.sv
// Request/response bus between a client (master) and the SRAM controller (slave).
interface sram_sp_be_ctrl_if
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
);

  localparam int NBYTE = DATA_W / BYTE_W;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [NBYTE-1:0]  req_be;
  logic [ADDR_W-1:0] req_a;
  logic [DATA_W-1:0] req_d;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_q;
  logic              init_done;

  modport master (
    output req_valid, req_we, req_be, req_a, req_d,
    input  req_ready, rsp_valid, rsp_q, init_done
  );

  modport slave (
    input  req_valid, req_we, req_be, req_a, req_d,
    output req_ready, rsp_valid, rsp_q, init_done
  );

endinterface

// File: rtl/sram_sp_be_array.sv
// Synchronous single-port array: per-byte write enables, 1-cycle registered read.
module sram_sp_be_array
  import sram_ctrl_pkg::*;
#(
  parameter  int ADDR_W = 13,
  parameter  int DATA_W = 32,
  localparam int NBYTE  = DATA_W / BYTE_W,
  localparam int DEPTH  = 2 ** ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NBYTE-1:0]  i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_d,
  output logic [DATA_W-1:0] o_q
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q;

  // NOTE: the storage has no reset branch so it maps onto block RAM; contents are cleared by the controller's INIT sweep instead.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < NBYTE; b++) begin
      if (i_we[b]) begin
        r_mem[i_a][b*BYTE_W +: BYTE_W] <= i_d[b*BYTE_W +: BYTE_W];
      end
    end
  end

  // Read data only moves on a read, so it holds between responses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_re) begin
      r_q <= r_mem[i_a];
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/sram_sp_be_ctrl.sv
// SRAM controller: init/run FSM, request acceptance, read-valid pipeline and optional output register.
module sram_sp_be_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter  int ADDR_W    = 13,
  parameter  int DATA_W    = 32,
  parameter  int OUT_REG   = 1,
  parameter  int INIT_ZERO = 1,
  localparam int NBYTE     = DATA_W / BYTE_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  sram_sp_be_ctrl_if.slave  bus
);

  state_e            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_ready;
  logic              r_init_done;

  logic              w_acc;
  logic [NBYTE-1:0]  w_we;
  logic              w_re;
  logic [ADDR_W-1:0] w_a;
  logic [DATA_W-1:0] w_d;
  logic [DATA_W-1:0] w_arr_q;

  // NOTE: every state and output register uses <= so all of them see the same pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_ready     <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (INIT_ZERO == 0 || r_cnt == '1) begin
            r_state     <= ST_RUN;
            r_ready     <= 1'b1;
            r_init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          r_ready     <= 1'b1;
          r_init_done <= 1'b1;
        end
      endcase
    end
  end

  assign w_acc = bus.req_valid && r_ready;

  // NOTE: each output gets a default first so no path through this block can infer a latch.
  always_comb begin
    w_we = '0;
    w_re = 1'b0;
    w_a  = r_cnt;
    w_d  = '0;
    if (!i_rst) begin
      if (r_state == ST_INIT) begin
        if (INIT_ZERO != 0) w_we = '1;
      end else if (w_acc) begin
        w_a = bus.req_a;
        w_d = bus.req_d;
        if (bus.req_we) w_we = bus.req_be;
        else            w_re = 1'b1;
      end
    end
  end

  sram_sp_be_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_we  (w_we),
    .i_re  (w_re),
    .i_a   (w_a),
    .i_d   (w_d),
    .o_q   (w_arr_q)
  );

  if (OUT_REG != 0) begin : g_oreg
    logic [1:0]        r_vpipe;
    logic [DATA_W-1:0] r_q;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_vpipe <= '0;
        r_q     <= '0;
      end else begin
        r_vpipe <= {r_vpipe[0], w_re};
        if (r_vpipe[0]) r_q <= w_arr_q;
      end
    end

    assign bus.rsp_valid = r_vpipe[1];
    assign bus.rsp_q     = r_q;
  end else begin : g_noreg
    logic r_vpipe;

    always_ff @(posedge i_clk) begin
      if (i_rst) r_vpipe <= 1'b0;
      else       r_vpipe <= w_re;
    end

    assign bus.rsp_valid = r_vpipe;
    assign bus.rsp_q     = w_arr_q;
  end

  assign bus.req_ready = r_ready;
  assign bus.init_done = r_init_done;

endmodule
